// File: rtl/sobel_axis_adapter_pkg.sv
// Shared constants and FSM state type for the Sobel AXI4-Stream adapter.
package sobel_pkg;
  localparam int PIXELS_PER_BEAT = 16;
  localparam int IMAGE_DIM       = 512;
  localparam int BPL             = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int BPF             = BPL * IMAGE_DIM;
  localparam int LAG             = BPL;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, RESYNC} state_t;
endpackage

// File: rtl/sobel_axis_adapter_if.sv
// AXI4-Stream beat bundle with tlast (end of line) and tuser (start of frame).
interface sobel_axis_adapter_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/sobel_axis_adapter_fifo2.sv
// Two-entry output FIFO carrying data plus tlast/tuser; a pop in the same cycle never frees a slot for a push.
module axis_skid_fifo2 #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  push_user,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic                  head_user,
  output logic                  full,
  output logic                  empty
);
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [1:0]            last_q;
  logic [1:0]            user_q;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Payload storage is not reset; flags are masked by empty instead.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_q[wr_ptr] <= push_data;
      last_q[wr_ptr] <= push_last;
      user_q[wr_ptr] <= push_user;
    end
  end

  assign head_data = data_q[rd_ptr];
  assign head_last = ~empty & last_q[rd_ptr];
  assign head_user = ~empty & user_q[rd_ptr];
endmodule

// File: rtl/sobel_axis_adapter.sv
// AXI4-Stream wrapper around the stall-driven Sobel stage: backpressure becomes one global
// stall, and a tag chain following the pipeline depth decides which Sobel outputs form the frame.
module sobel_axis_adapter #(
  parameter int PIXELS_PER_BEAT = sobel_pkg::PIXELS_PER_BEAT,
  parameter int IMAGE_DIM       = sobel_pkg::IMAGE_DIM,
  parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
  parameter int LATENCY         = 20
) (
  input  logic                  clk,
  input  logic                  aresetn,
  sobel_axis_adapter_if.slave   s_axis,
  sobel_axis_adapter_if.master  m_axis,
  output logic [DATA_WIDTH-1:0] sob_inp_frame,
  output logic                  sob_stall,
  output logic                  sob_aresetn,
  input  logic [DATA_WIDTH-1:0] sob_out_frame,
  output logic                  err_framing,
  output logic                  busy
);
  import sobel_pkg::*;

  localparam int LINE_BEATS  = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int FRAME_BEATS = LINE_BEATS * IMAGE_DIM;
  localparam int LAG_BEATS   = LINE_BEATS;
  localparam int LAST_IDX    = FRAME_BEATS + LAG_BEATS + LATENCY - 1;
  localparam int IW          = $clog2(LAST_IDX + 1);
  localparam int CW          = ($clog2(LINE_BEATS) > 0) ? $clog2(LINE_BEATS) : 1;
  localparam int OW          = ($clog2(FRAME_BEATS) > 0) ? $clog2(FRAME_BEATS) : 1;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       in_col;
  logic [CW-1:0]       out_col;
  logic [OW-1:0]       out_idx;
  logic [LATENCY-1:0]  tag_v;
  logic                in_idle, in_run, in_flush;
  logic                tail, fifo_full, fifo_empty, ok, advance, push, drop, bad_beat, tag_in;

  assign in_idle  = (state == IDLE);
  assign in_run   = (state == RUN);
  assign in_flush = (state == FLUSH);
  assign tail     = tag_v[LATENCY-1];
  assign ok       = ~tail | ~fifo_full;
  assign advance  = in_run ? (s_axis.tvalid & ok) : (in_flush & ok);
  assign push     = advance & tail;
  assign drop     = in_idle & s_axis.tvalid & ~s_axis.tuser;
  // The first LAG beats only prime the line buffer; their outputs are not part of the frame.
  assign tag_in   = (idx >= IW'(LAG_BEATS));
  assign bad_beat = in_run & advance &
                    ((s_axis.tlast != (in_col == CW'(LINE_BEATS - 1))) |
                     (s_axis.tuser & (idx != '0)));

  assign s_axis.tready = (in_run & ok) | drop;
  assign sob_stall     = ~advance;
  assign sob_inp_frame = in_run ? s_axis.tdata : '0;

  axis_skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .aresetn   (aresetn),
    .push      (push),
    .push_data (sob_out_frame),
    .push_last (out_col == CW'(LINE_BEATS - 1)),
    .push_user (out_idx == '0),
    .pop       (m_axis.tready),
    .head_data (m_axis.tdata),
    .head_last (m_axis.tlast),
    .head_user (m_axis.tuser),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
  assign m_axis.tvalid = ~fifo_empty;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= RESYNC;
      idx         <= '0;
      in_col      <= '0;
      out_col     <= '0;
      out_idx     <= '0;
      tag_v       <= '0;
      sob_aresetn <= 1'b0;
      busy        <= 1'b0;
      err_framing <= 1'b0;
    end else begin
      if (bad_beat | drop) err_framing <= 1'b1;
      if (advance) tag_v <= (tag_v << 1) | LATENCY'(tag_in);
      if (push) begin
        out_col <= (out_col == CW'(LINE_BEATS - 1)) ? '0 : out_col + 1'b1;
        out_idx <= (out_idx == OW'(FRAME_BEATS - 1)) ? '0 : out_idx + 1'b1;
      end
      case (state)
        IDLE: begin
          if (s_axis.tvalid & s_axis.tuser) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (advance) begin
            idx    <= idx + 1'b1;
            in_col <= (in_col == CW'(LINE_BEATS - 1)) ? '0 : in_col + 1'b1;
            if (idx == IW'(FRAME_BEATS - 1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (advance) begin
            if (idx == IW'(LAST_IDX)) begin
              state       <= RESYNC;
              sob_aresetn <= 1'b0;
              idx         <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          // Leftover tags past the frame die here together with the Sobel stage reset.
          state       <= IDLE;
          sob_aresetn <= 1'b1;
          busy        <= 1'b0;
          tag_v       <= '0;
          idx         <= '0;
          in_col      <= '0;
          out_col     <= '0;
          out_idx     <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_axis_adapter.sv
// Bench for sobel_axis_adapter with a LATENCY-deep pass-through stand-in for the Sobel stage.
`timescale 1ns/1ps
module tb_sobel_axis_adapter;
  localparam int PPB = 16;
  localparam int DIM = 64;
  localparam int LAT = 6;
  localparam int DW  = 8 * PPB;
  localparam int BPL = DIM / PPB;
  localparam int BPF = BPL * DIM;
  localparam int LAG = BPL;

  typedef logic [DW+1:0] beat_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  sobel_axis_adapter_if #(.DATA_WIDTH(DW)) s_if ();
  sobel_axis_adapter_if #(.DATA_WIDTH(DW)) m_if ();

  logic [DW-1:0] sob_inp_frame, sob_out_frame;
  logic          sob_stall, sob_aresetn, err_framing, busy;

  sobel_axis_adapter #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk(clk), .aresetn(aresetn), .s_axis(s_if), .m_axis(m_if),
    .sob_inp_frame(sob_inp_frame), .sob_stall(sob_stall), .sob_aresetn(sob_aresetn),
    .sob_out_frame(sob_out_frame), .err_framing(err_framing), .busy(busy)
  );

  // Stand-in Sobel stage: LAT registers that advance only when not stalled.
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (!sob_aresetn) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else if (!sob_stall) begin
      pipe[0] <= sob_inp_frame;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign sob_out_frame = pipe[LAT-1];

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    first_vld = -1;
  int    low_cnt = 0;
  beat_t got_q[$];
  beat_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (aresetn && m_if.tvalid && m_if.tready) got_q.push_back({m_if.tdata, m_if.tlast, m_if.tuser});
    if (m_if.tvalid && first_vld < 0) first_vld = cyc;
    if (!sob_aresetn) low_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got time %0t want < 1ms", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
    m_if.tready = 1'b1;
    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();
  endtask

  // Drives one frame of random beats and appends the expected output frame to exp_q.
  task automatic drive_frame(input int gap_pct, input int bad_beat, input bit chk_stall,
                             output int acc_cyc, output int low_at_start);
    logic [DW-1:0] f [BPF];
    logic [DW-1:0] d;
    int  i = 0;
    int  guard = 0;
    bit  pend = 1'b0;
    for (int k = 0; k < BPF; k++) f[k] = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < BPF; n++) begin
      d = (n + LAG < BPF) ? f[n+LAG] : {DW{1'b0}};
      exp_q.push_back({d, (n % BPL) == BPL - 1, n == 0});
    end
    acc_cyc = -1;
    low_at_start = -1;
    while (i < BPF && guard < 5000) begin
      if (!pend && $urandom_range(99) < gap_pct) begin
        s_if.tvalid = 1'b0;
      end else begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = f[i];
        s_if.tuser  = (i == 0);
        s_if.tlast  = ((i % BPL) == BPL - 1) ^ (i == bad_beat);
      end
      @(negedge clk);
      if (chk_stall && i > 0) begin
        vectors++;
        if (sob_stall !== !s_if.tvalid) begin
          miscompares++;
          $display("FAIL stall_on_gap beat %0d: sob_stall=%b want %b", i, sob_stall, !s_if.tvalid);
        end
      end
      pend = s_if.tvalid && !s_if.tready;
      if (s_if.tvalid && s_if.tready) begin
        if (i == 0) begin acc_cyc = cyc; low_at_start = low_cnt; end
        i++;
      end
      @(posedge clk); #1;
      guard++;
    end
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
    vectors++;
    if (i != BPF) begin
      miscompares++;
      $display("FAIL drive_timeout: accepted %0d beats want %0d", i, BPF);
    end
  endtask

  task automatic check_frame(input string name);
    for (int c = 0; c < 4000 && got_q.size() < exp_q.size(); c++) @(negedge clk);
    repeat (30) @(negedge clk);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d beats want %0d", name, got_q.size(), exp_q.size());
    end
    for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
      vectors++;
      if (got_q[n] !== exp_q[n]) begin
        miscompares++;
        $display("FAIL %s_beat%0d: got %h want %h", name, n, got_q[n], exp_q[n]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
    m_if.tready = 1'b1;
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({s_if.tready, m_if.tvalid, m_if.tlast, m_if.tuser, sob_stall, sob_aresetn, err_framing, busy} !== 8'b0000_1000) begin
      miscompares++;
      $display("FAIL reset_outputs: got tready/tvalid/tlast/tuser/stall/sob_rst/err/busy=%b want 00001000",
               {s_if.tready, m_if.tvalid, m_if.tlast, m_if.tuser, sob_stall, sob_aresetn, err_framing, busy});
    end
    @(posedge clk); #1 aresetn = 1'b1;
    @(negedge clk);
    vectors++;
    if (sob_aresetn !== 1'b0) begin
      miscompares++;
      $display("FAIL resync_cycle: sob_aresetn=%b want 0", sob_aresetn);
    end
    @(negedge clk);
    vectors++;
    if ({sob_aresetn, busy, s_if.tready} !== 3'b100) begin
      miscompares++;
      $display("FAIL idle_after_reset: sob_aresetn/busy/tready=%b want 100", {sob_aresetn, busy, s_if.tready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_continuous();
    int acc, low;
    first_vld = -1;
    drive_frame(0, -1, 1'b1, acc, low);
    check_frame("continuous");
    vectors++;
    if (first_vld - acc !== LAG + LAT + 1) begin
      miscompares++;
      $display("FAIL first_latency: got %0d cycles want %0d", first_vld - acc, LAG + LAT + 1);
    end
    vectors++;
    if (err_framing !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_err: err_framing=%b want 0", err_framing);
    end
  endtask

  task automatic test_backpressure();
    int acc, low;
    logic [DW-1:0] held;
    fork
      drive_frame(0, -1, 1'b0, acc, low);
      begin : stall_thread
        for (int w = 0; w < 2000 && got_q.size() < 40; w++) @(negedge clk);
        @(posedge clk); #1 m_if.tready = 1'b0;
        held = m_if.tdata;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          vectors++;
          if ({m_if.tvalid, m_if.tdata} !== {1'b1, held}) begin
            miscompares++;
            $display("FAIL hold_stable c%0d: tvalid=%b tdata=%h want 1 %h", c, m_if.tvalid, m_if.tdata, held);
          end
        end
        vectors++;
        if ({sob_stall, s_if.tready} !== 2'b10) begin
          miscompares++;
          $display("FAIL full_stall: sob_stall/tready=%b want 10", {sob_stall, s_if.tready});
        end
        @(posedge clk); #1 m_if.tready = 1'b1;
      end
    join
    check_frame("backpressure");
  endtask

  task automatic test_gaps();
    int acc, low;
    drive_frame(30, -1, 1'b1, acc, low);
    check_frame("gaps");
  endtask

  task automatic test_framing();
    int acc, low;
    drive_frame(0, 2, 1'b0, acc, low);
    vectors++;
    if (err_framing !== 1'b1) begin
      miscompares++;
      $display("FAIL tlast_err: err_framing=%b want 1", err_framing);
    end
    check_frame("framing");
    vectors++;
    if (err_framing !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: err_framing=%b want 1", err_framing);
    end
  endtask

  task automatic test_idle_drop();
    s_if.tvalid = 1'b1; s_if.tuser = 1'b0; s_if.tlast = 1'b0; s_if.tdata = {4{$urandom}};
    @(negedge clk);
    vectors++;
    if (s_if.tready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_drop_ready: tready=%b want 1", s_if.tready);
    end
    @(posedge clk); #1 s_if.tvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({err_framing, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL idle_drop_err: err/busy=%b want 10", {err_framing, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc1, low1, acc2, low2;
    low_cnt = 0;
    drive_frame(0, -1, 1'b0, acc1, low1);
    drive_frame(0, -1, 1'b0, acc2, low2);
    vectors++;
    if (low2 - low1 !== 1) begin
      miscompares++;
      $display("FAIL resync_gap: sob_aresetn low %0d cycles between frames want 1", low2 - low1);
    end
    check_frame("back_to_back");
  endtask

  task automatic test_reset_flush();
    int acc, low;
    drive_frame(0, -1, 1'b0, acc, low);
    repeat (3) @(posedge clk);
    #3;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_busy: busy=%b want 1", busy);
    end
    aresetn = 1'b0;
    #1;
    vectors++;
    if ({s_if.tready, m_if.tvalid, m_if.tlast, m_if.tuser, sob_stall, sob_aresetn, err_framing, busy} !== 8'b0000_1000) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got %b want 00001000",
               {s_if.tready, m_if.tvalid, m_if.tlast, m_if.tuser, sob_stall, sob_aresetn, err_framing, busy});
    end
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got_q.delete(); exp_q.delete();
    drive_frame(0, -1, 1'b0, acc, low);
    check_frame("after_reset");
    vectors++;
    if (err_framing !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_err: err_framing=%b want 0", err_framing);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_backpressure();
    test_gaps();
    test_framing();
    do_reset();
    test_idle_drop();
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sobel_axis_adapter.md
Name: sobel_axis_adapter

Overview:
- AXI4-Stream front/back end for the stall-driven Sobel stage; sits directly upstream (drives its input beat, stall and reset) and captures its output.
- Converts ready/valid backpressure into the single global stall.
- Tags beats through the fixed pipeline latency, appends one zero padding row plus drain beats per frame, and re-emits exactly one frame of output with regenerated tlast/tuser.

Parameters:
- PIXELS_PER_BEAT, 16, pixels per beat.
- IMAGE_DIM, 512, square frame side in pixels.
- DATA_WIDTH, 8*PIXELS_PER_BEAT, beat width.
- LATENCY, 20, Sobel-stage depth in advances (input beat to valid out_frame). Set at integration.
- Derived: BPL=IMAGE_DIM/PIXELS_PER_BEAT; BPF=BPL*IMAGE_DIM; LAG=BPL.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, active-low, asynchronous.
- s_axis_tdata  in  DATA_WIDTH  input pixels.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of line.
- s_axis_tuser  in  1  start of frame.
- sob_inp_frame  out  DATA_WIDTH  beat to Sobel stage.
- sob_stall  out  1  freezes Sobel stage.
- sob_aresetn  out  1  synchronous reset to Sobel stage.
- sob_out_frame  in  DATA_WIDTH  Sobel result.
- m_axis_tdata  out  DATA_WIDTH  edge pixels.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  end of output line.
- m_axis_tuser  out  1  first beat of output frame.
- err_framing  out  1  sticky tlast/tuser mismatch.
- busy  out  1  frame in progress.

Behaviour:
- Reset: all state asynchronously cleared. Outputs at reset: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, sob_stall=1, sob_aresetn=0 (registered), err_framing=0, busy=0. State=RESYNC.
- State machine IDLE -> RUN -> FLUSH -> RESYNC -> IDLE.
  - IDLE: waits for s_axis_tvalid & s_axis_tuser, then enters RUN without consuming the beat. A valid beat without tuser is dropped (tready=1) and sets err_framing.
  - RUN: accepts BPF beats, then enters FLUSH.
  - FLUSH: injects LAG+LATENCY zero beats.
  - RESYNC: one cycle with sob_aresetn=0, then IDLE.
- Tag shift register v[0..LATENCY-1] shifts only on advance. v[0] <= (beat is accepted or injected) & (stream index >= LAG), where stream index counts from 0 over RUN+FLUSH beats. sob_out_frame is valid whenever v[LATENCY-1]=1.
- Output FIFO: 2 entries. space = (count<2). Same-cycle pop is not credited.
- ok = ~v[LATENCY-1] | space.
- advance = RUN ? (s_axis_tvalid & ok) : (FLUSH & ok).
- s_axis_tready = RUN & ok. sob_stall = ~advance (combinational).
- sob_inp_frame = RUN ? s_axis_tdata : 0.
- On advance & v[LATENCY-1], sob_out_frame is pushed into the FIFO in the same cycle.
- Output counters: output column wraps at BPL; output beat index runs over BPF.
  - m_axis_tlast=1 on column BPL-1.
  - m_axis_tuser=1 on index 0.
  - tlast/tuser are stored with the data in the FIFO.
- FIFO drives m_axis_tdata/tvalid directly. Data is held stable while tvalid & ~tready.
- Input check during RUN: s_axis_tlast must equal (input column==BPL-1), and s_axis_tuser must be 0 except on beat 0. A mismatch sets err_framing (sticky until reset). The beat is still consumed, so the count stays authoritative.
- busy=1 in RUN, FLUSH, RESYNC.
- Latency: first m_axis beat appears LAG+LATENCY advances after the first accepted beat, plus 1 cycle for the FIFO.
- Boundaries:
  - FIFO full with v tail set: stall, hold everything.
  - Simultaneous FIFO push and pop with count=2 is not permitted, because ok was 0.
  - Asynchronous reset mid-frame: the FIFO and all in-flight tags are discarded. sob_aresetn is held low through reset plus the RESYNC cycle.
  - Counters wrap exactly at BPL/BPF. No output beat beyond BPF per frame.

Decomposition:
- Package sobel_pkg holds: PIXELS_PER_BEAT, IMAGE_DIM, derived BPL/BPF/LAG, and the state enum {IDLE, RUN, FLUSH, RESYNC}.
- One natural sub-module: axis_skid_fifo2 (2-entry FIFO, data+tlast+tuser, full/empty).

Test Plan:
- Bench configuration: IMAGE_DIM=64, PPB=16, LATENCY=6, giving BPL=4, BPF=256. The Sobel stage is replaced by a LATENCY-deep model.
- Continuous valid/ready: one frame of 256 beats -> 256 output beats with 4-beat offset alignment; tlast on beats 3,7,...,255; tuser on beat 0 only; first m_axis_tvalid 11 cycles after first accept.
- m_axis_tready low for 50 cycles mid-frame -> sob_stall=1 within FIFO depth, no loss or duplication, tdata held stable.
- Random s_axis_tvalid gaps at 30% -> stall asserted exactly on gap cycles, output sequence identical to gapless run.
- s_axis_tlast asserted on beat 2 -> err_framing=1 and stays 1; frame still completes with 256 outputs.
- Beat without tuser in IDLE -> dropped, err_framing=1. Two back-to-back frames -> sob_aresetn low exactly one cycle between them.
- aresetn pulsed low mid-FLUSH -> all outputs return to reset values immediately; the next frame is clean.
